fb_pattern_writer: RTL



---
 rtl/fb_pattern_writer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fb_pattern_writer.sv
// Wishbone write master that fills a raster framebuffer with one of four test
// patterns, one 32-bit word per pixel, yielding the bus every BURST writes.
module fb_pattern_writer #(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int BURST = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [23:0] color,
  output logic        busy,
  output logic        done,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [31:0] wshb_adr,
  output logic [31:0] wshb_dat_ms,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack
);

  localparam int NPIX = HDISP * VDISP;
  localparam int IW   = $clog2(NPIX);
  localparam int XW   = $clog2(HDISP + 1);
  localparam int YW   = $clog2(VDISP + 1);
  localparam int BW   = (HDISP / 8 > 0) ? HDISP / 8 : 1;
  localparam int BPW  = $clog2(BW + 1);
  localparam int CW   = $clog2(BURST + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]     state;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  burst_cnt;
  logic [2:0]     bar;
  logic [BPW-1:0] bar_pix;
  logic [1:0]     mode_q;
  logic [23:0]    color_q;

  logic last_pix, last_x, burst_end, bar_end;

  assign last_pix  = (idx == IW'(NPIX - 1));
  assign last_x    = (x == XW'(HDISP - 1));
  assign burst_end = (burst_cnt == CW'(BURST - 1));
  assign bar_end   = (bar_pix == BPW'(BW - 1));

  // NOTE: reset is sampled on the clock edge and all state uses non-blocking
  // assignments so every register updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      x         <= '0;
      y         <= '0;
      idx       <= '0;
      burst_cnt <= '0;
      bar       <= '0;
      bar_pix   <= '0;
      mode_q    <= '0;
      color_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q    <= mode;
            color_q   <= color;
            x         <= '0;
            y         <= '0;
            idx       <= '0;
            burst_cnt <= '0;
            bar       <= '0;
            bar_pix   <= '0;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wshb_ack) begin
            idx <= idx + 1'b1;
            if (last_x) begin
              x       <= '0;
              y       <= y + 1'b1;
              bar     <= '0;
              bar_pix <= '0;
            end else begin
              x <= x + 1'b1;
              // Bar index tracks x / BW without a divider; it stops at the last bar.
              if (bar_end) begin
                bar_pix <= '0;
                if (bar != 3'd7) bar <= bar + 1'b1;
              end else begin
                bar_pix <= bar_pix + 1'b1;
              end
            end
            if (last_pix) begin
              state <= S_DONE;
            end else if (burst_end) begin
              burst_cnt <= '0;
              state     <= S_PAUSE;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
        end
        S_PAUSE: state <= S_WRITE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [7:0]  x8, y8;
  logic [23:0] pix;

  assign x8 = 8'(x);
  assign y8 = 8'(y);

  // NOTE: pix gets a default before the case so no path can infer a latch.
  always_comb begin
    pix = 24'h000000;
    case (mode_q)
      2'd0: pix = (x8[3:0] == 4'd0 || y8[3:0] == 4'd0) ? 24'hFFFFFF : 24'h000000;
      2'd1: begin
        case (bar)
          3'd0:    pix = 24'hFFFFFF;
          3'd1:    pix = 24'hFFFF00;
          3'd2:    pix = 24'h00FFFF;
          3'd3:    pix = 24'h00FF00;
          3'd4:    pix = 24'hFF00FF;
          3'd5:    pix = 24'hFF0000;
          3'd6:    pix = 24'h0000FF;
          default: pix = 24'h000000;
        endcase
      end
      2'd2:    pix = {x8, y8, x8 + y8};
      default: pix = color_q;
    endcase
  end

  logic writing;
  assign writing = (state == S_WRITE);

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign wshb_cyc    = writing;
  assign wshb_stb    = writing;
  assign wshb_we     = writing;
  assign wshb_adr    = writing ? 32'({idx, 2'b00}) : 32'h0;
  assign wshb_dat_ms = writing ? {8'h00, pix} : 32'h0;
  assign wshb_sel    = 4'b1111;
  assign wshb_cti    = 3'b000;
  assign wshb_bte    = 2'b00;

endmodule
